// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first) fed by a small circular FIFO, so bursts of
// bytes can be queued at clock rate while the serializer drains them at baud rate.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst_L,
  input  logic                             i_TX_DV,
  input  logic [7:0]                       i_TX_Byte,
  output logic                             o_TX_Ready,
  output logic                             o_TX_Overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_FIFO_Count,
  output logic                             o_TX_Serial,
  output logic                             o_TX_Active,
  output logic                             o_TX_Done,
  output logic [1:0]                       o_Dbg_State
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam logic [CLK_W-1:0] LAST_CLK = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CLK_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             wr_en;
  logic             pop;
  logic             bit_end;

  // Handshake: a byte is taken on any rising edge where i_TX_DV and o_TX_Ready
  // are both high; o_TX_Ready comes from the registered count only, so a pop on
  // the same edge never frees a slot for a write presented while full.
  assign o_TX_Ready   = (count != FULL_CNT);
  assign wr_en        = i_TX_DV && o_TX_Ready;
  assign bit_end      = (clk_cnt == LAST_CLK);
  assign pop          = (count != '0) && ((state == IDLE) || (state == STOP && bit_end));
  assign o_FIFO_Count = count;
  assign o_Dbg_State  = state;

  always_ff @(posedge i_Clk) begin
    if (wr_en) mem[wr_ptr] <= i_TX_Byte;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_TX_Overflow <= 1'b0;
    end else begin
      o_TX_Overflow <= i_TX_DV && !o_TX_Ready;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The line value is registered and set one state ahead, so it changes on the
  // same edge the state does and the frame is exactly 10 bit periods long.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'd0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      clk_cnt   <= bit_end ? '0 : clk_cnt + CLK_W'(1);
      case (state)
        IDLE: begin
          clk_cnt     <= '0;
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b0;
          if (pop) begin
            shift       <= mem[rd_ptr];
            state       <= START;
            o_TX_Serial <= 1'b0;
            o_TX_Active <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state       <= DATA;
            bit_idx     <= 3'd0;
            o_TX_Serial <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state       <= STOP;
              o_TX_Serial <= 1'b1;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_TX_Serial <= shift[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            o_TX_Done <= 1'b1;
            if (pop) begin
              shift       <= mem[rd_ptr];
              state       <= START;
              o_TX_Serial <= 1'b0;
            end else begin
              state       <= IDLE;
              o_TX_Active <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter (8N1, LSB first) with a small input FIFO; the transmit-direction counterpart of the board's UART receiver. Lets game logic (score/status reporting) push bytes in bursts at i_Clk rate while the serializer drains them at the configured baud rate. It sits between the game core and the board's UART TX pin, sharing the same 25 MHz i_Clk domain.

Parameters:
CLKS_PER_BIT, 217, i_Clk cycles per bit period (25,000,000/115,200); legal range >= 2.
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
i_Clk  input  1  system clock; all logic on the rising edge.
i_Rst_L  input  1  asynchronous reset, active low.
i_TX_DV  input  1  write strobe; byte accepted on an edge where i_TX_DV=1 and o_TX_Ready=1.
i_TX_Byte  input  8  byte to queue.
o_TX_Ready  output  1  FIFO not full (count != FIFO_DEPTH).
o_TX_Overflow  output  1  one-cycle pulse when a write is presented while the FIFO is full.
o_FIFO_Count  output  $clog2(FIFO_DEPTH+1)  bytes queued, excluding the byte being serialized.
o_TX_Serial  output  1  serial line; idles high.
o_TX_Active  output  1  high while a frame (start..stop) is on the line.
o_TX_Done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (async assert, sync release): o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Overflow=0, o_FIFO_Count=0, o_TX_Ready=1. FIFO emptied, state=IDLE. Reset mid-frame truncates the frame; the line goes high immediately.
- FIFO: registered, circular read/write pointers. Write and pop on the same edge are allowed; count +1, -1 or unchanged accordingly. o_TX_Ready derives from the registered count; a write while full is rejected even when a pop occurs on the same edge. A rejected write leaves the FIFO unchanged and pulses o_TX_Overflow on the next cycle.
- States: IDLE, START, DATA, STOP.
- IDLE: o_TX_Serial=1, o_TX_Active=0. If count>0, pop the head into the shift register and go to START.
- START: o_TX_Serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: o_TX_Serial=shift[index] for CLKS_PER_BIT cycles per bit, indices 0..7. After index 7, go to STOP.
- STOP: o_TX_Serial=1 for CLKS_PER_BIT cycles. On the final stop cycle, pulse o_TX_Done. If count>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- o_TX_Active=1 in START, DATA and STOP.
- Latency: DV sampled at edge k into an empty FIFO with the serializer idle → count=1 after k → pop at edge k+1 → o_TX_Serial=0 from edge k+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Bit counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Data is latched at pop; later changes to i_TX_Byte do not affect a frame in flight.

Test Plan:
1. Single byte, CLKS_PER_BIT=217: write 0xA5 into an idle block → line is 0, then 1,0,1,0,0,1,0,1, then 1, each held 217 cycles. o_TX_Active high for 2170 cycles. One o_TX_Done pulse at the end of the stop bit.
2. Burst with CLKS_PER_BIT=4: write 0x00, 0xFF, 0x55 on consecutive cycles → 120 contiguous cycles of framed data with no idle gap. Exactly three o_TX_Done pulses, 40 cycles apart. o_FIFO_Count sequence 1,1,2 then decrements at each frame boundary.
3. Overflow, FIFO_DEPTH=4, 6 writes on consecutive cycles into an idle block → writes 1–5 accepted (first popped at edge 1). o_TX_Ready=0 after the 5th. 6th write dropped with one o_TX_Overflow pulse. Line carries exactly 5 frames in order.
4. Simultaneous write and pop at count=4 → write rejected, count becomes 3. At count=3 with write and pop on the same edge → count stays 3 and the byte is retained.
5. Reset mid-frame: assert i_Rst_L=0 during DATA bit 3 → o_TX_Serial=1 and o_TX_Active=0 immediately. Count=0 after release. No o_TX_Done pulse. A new write after release transmits a clean frame.
6. Data hold: change i_TX_Byte every cycle after an accepted write of 0x3C → transmitted bits match 0x3C.
